// File: rtl/regular_mode_code_sequencer_pkg.sv
// Shared defaults, state encoding and width helper for the regular-mode code sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regular_mode_code_sequencer_pkg;

   localparam int MERR_W_DEF  = 9;
   localparam int K_W_DEF     = 4;
   localparam int QBPP_DEF    = 8;
   localparam int LIMIT_DEF   = 32;
   localparam int CHUNK_W_DEF = 16;
   localparam int LEN_W_DEF   = 5;
   localparam int QMAX_DEF    = LIMIT_DEF - QBPP_DEF - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ZEROS = 2'd1,
      ST_TAIL  = 2'd2
   } seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/regular_mode_code_sequencer_planner.sv
// Plans one Golomb codeword: unary zero count, terminating-one tail and tail length, escape flag.
// Latency: purely combinational.
// Backpressure: none; the sequencer samples the plan only when it accepts an input.
module regular_code_planner
   import regular_mode_code_sequencer_pkg::*;
#(
   parameter int MERR_W = MERR_W_DEF,
   parameter int K_W    = K_W_DEF,
   parameter int QBPP   = QBPP_DEF,
   parameter int LIMIT  = LIMIT_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int ZCNT_W = $clog2(LIMIT - QBPP),
   parameter int TAIL_W = max_int(QBPP + 1, MERR_W + 1)
) (
   input  logic [MERR_W-1:0] merr,
   input  logic [K_W-1:0]    k,
   output logic [ZCNT_W-1:0] zeros,
   output logic [TAIL_W-1:0] tail,
   output logic [LEN_W-1:0]  tail_len,
   output logic              is_escape
);

   localparam int QMAX = LIMIT - QBPP - 1;

   logic [K_W-1:0]    k_eff;
   logic [MERR_W-1:0] q;
   logic [MERR_W-1:0] mask;
   logic [QBPP-1:0]   merr_m1_lo;

   // Clamp k, split MErrval into quotient/remainder and pick plain or escape form.
   always_comb begin
      k_eff = k;
      if (k > K_W'(MERR_W)) begin
         k_eff = K_W'(MERR_W);
      end
      q          = merr >> k_eff;
      // at k_eff == MERR_W the shifted one falls off and the mask becomes all ones
      mask       = (MERR_W'(1) << k_eff) - MERR_W'(1);
      merr_m1_lo = QBPP'(merr - MERR_W'(1));
      is_escape  = ({{(32-MERR_W){1'b0}}, q} >= 32'(QMAX));
      if (is_escape) begin
         zeros    = ZCNT_W'(QMAX);
         tail     = TAIL_W'({1'b1, merr_m1_lo});
         tail_len = LEN_W'(QBPP + 1);
      end else begin
         zeros    = ZCNT_W'(q);
         tail     = (TAIL_W'(1) << k_eff) | TAIL_W'(merr & mask);
         tail_len = LEN_W'(k_eff) + LEN_W'(1);
      end
   end

endmodule

// File: rtl/regular_mode_code_sequencer.sv
// Emits one regular-mode Golomb codeword as right-aligned beats of up to CHUNK_W bits.
// Latency: first beat valid the cycle after input accept; one beat per cycle while out_ready is high.
// Backpressure: beats held stable while out_ready is low; in_ready low until the last beat handshakes.
module regular_mode_code_sequencer
   import regular_mode_code_sequencer_pkg::*;
#(
   parameter int MERR_W  = MERR_W_DEF,
   parameter int K_W     = K_W_DEF,
   parameter int QBPP    = QBPP_DEF,
   parameter int LIMIT   = LIMIT_DEF,
   parameter int CHUNK_W = CHUNK_W_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MERR_W-1:0]  MErrval,
   input  logic [K_W-1:0]     k,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CHUNK_W-1:0] out_bits,
   output logic [LEN_W-1:0]   out_len,
   output logic               out_last,
   output logic               is_escape,
   output logic               busy
);

   localparam int ZCNT_W = $clog2(LIMIT - QBPP);
   localparam int TAIL_W = max_int(QBPP + 1, MERR_W + 1);
   localparam int SUM_W  = max_int(ZCNT_W, LEN_W) + 1;

   logic [ZCNT_W-1:0]  p_zeros;
   logic [TAIL_W-1:0]  p_tail;
   logic [LEN_W-1:0]   p_tail_len;
   logic               p_escape;

   seq_state_t         state_q, state_d;
   logic [ZCNT_W-1:0]  zeros_q, zeros_d;
   logic [TAIL_W-1:0]  tail_q, tail_d;
   logic [LEN_W-1:0]   tail_len_q, tail_len_d;
   logic               out_valid_q, out_valid_d;
   logic [CHUNK_W-1:0] out_bits_q, out_bits_d;
   logic [LEN_W-1:0]   out_len_q, out_len_d;
   logic               out_last_q, out_last_d;
   logic               is_escape_q, is_escape_d;

   logic               ld_beat;
   logic [ZCNT_W-1:0]  nz;
   logic [TAIL_W-1:0]  nt;
   logic [LEN_W-1:0]   ntl;
   logic [SUM_W-1:0]   nsum;

   regular_code_planner #(
      .MERR_W (MERR_W),
      .K_W    (K_W),
      .QBPP   (QBPP),
      .LIMIT  (LIMIT),
      .LEN_W  (LEN_W),
      .ZCNT_W (ZCNT_W),
      .TAIL_W (TAIL_W)
   ) u_planner (
      .merr      (MErrval),
      .k         (k),
      .zeros     (p_zeros),
      .tail      (p_tail),
      .tail_len  (p_tail_len),
      .is_escape (p_escape)
   );

   // Next-state and next-beat selection; a new beat is built on accept and after each zero beat.
   always_comb begin
      state_d     = state_q;
      zeros_d     = zeros_q;
      tail_d      = tail_q;
      tail_len_d  = tail_len_q;
      out_valid_d = out_valid_q;
      out_bits_d  = out_bits_q;
      out_len_d   = out_len_q;
      out_last_d  = out_last_q;
      is_escape_d = is_escape_q;
      ld_beat     = 1'b0;
      nz          = zeros_q;
      nt          = tail_q;
      ntl         = tail_len_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               ld_beat     = 1'b1;
               nz          = p_zeros;
               nt          = p_tail;
               ntl         = p_tail_len;
               is_escape_d = p_escape;
            end
         end
         ST_ZEROS: begin
            if (out_ready) begin
               ld_beat = 1'b1;
               // the zero beat just sent carried out_len_q zeros
               nz      = zeros_q - ZCNT_W'(out_len_q);
            end
         end
         ST_TAIL: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               out_bits_d  = '0;
               out_len_d   = '0;
               out_last_d  = 1'b0;
               is_escape_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      nsum = SUM_W'(nz) + SUM_W'(ntl);
      if (ld_beat) begin
         zeros_d     = nz;
         tail_d      = nt;
         tail_len_d  = ntl;
         out_valid_d = 1'b1;
         if (nsum <= SUM_W'(CHUNK_W)) begin
            // remaining zeros and the tail share one final beat
            state_d    = ST_TAIL;
            out_bits_d = CHUNK_W'(nt);
            out_len_d  = LEN_W'(nsum);
            out_last_d = 1'b1;
         end else begin
            // a zero run shorter than a chunk that cannot share with the tail goes out alone,
            // so the codeword never carries more zeros than planned
            state_d    = ST_ZEROS;
            out_bits_d = '0;
            out_len_d  = (SUM_W'(nz) >= SUM_W'(CHUNK_W)) ? LEN_W'(CHUNK_W) : LEN_W'(nz);
            out_last_d = 1'b0;
         end
      end
   end

   // State, zero counter and registered beat outputs; reset aborts any codeword in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         zeros_q     <= '0;
         tail_q      <= '0;
         tail_len_q  <= '0;
         out_valid_q <= 1'b0;
         out_bits_q  <= '0;
         out_len_q   <= '0;
         out_last_q  <= 1'b0;
         is_escape_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         zeros_q     <= zeros_d;
         tail_q      <= tail_d;
         tail_len_q  <= tail_len_d;
         out_valid_q <= out_valid_d;
         out_bits_q  <= out_bits_d;
         out_len_q   <= out_len_d;
         out_last_q  <= out_last_d;
         is_escape_q <= is_escape_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_bits  = out_bits_q;
   assign out_len   = out_len_q;
   assign out_last  = out_last_q;
   assign is_escape = is_escape_q;

endmodule

// File: tb/tb_regular_mode_code_sequencer.sv
// Scoreboard bench for the regular-mode code sequencer: directed codewords, stalls and mid-codeword reset.
// Latency: checks first beat at accept+1 and no bubbles between beats.
// Backpressure: stalls out_ready and checks beats are held bit-exact.
module tb_regular_mode_code_sequencer;
   import regular_mode_code_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  MErrval;
   logic [3:0]  k;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bits;
   logic [4:0]  out_len;
   logic        out_last;
   logic        is_escape;
   logic        busy;

   typedef struct packed {
      logic [15:0] bits;
      logic [4:0]  len;
      logic        last;
      logic        esc;
   } beat_t;

   beat_t exp_q[$];
   int    tests = 0;
   int    fails = 0;

   always #5 clk = ~clk;

   regular_mode_code_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .MErrval   (MErrval),
      .k         (k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .out_len   (out_len),
      .out_last  (out_last),
      .is_escape (is_escape),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expb(input logic [15:0] b, input logic [4:0] l, input logic last, input logic esc);
      beat_t e;
      e.bits = b;
      e.len  = l;
      e.last = last;
      e.esc  = esc;
      exp_q.push_back(e);
   endtask

   // Present one input in IDLE, then check the first beat is valid the following cycle.
   task automatic send(input logic [8:0] m, input logic [3:0] kk);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      MErrval  = m;
      k        = kk;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk("first_beat_valid_T+1", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      #3;
      while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 300) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (n >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: pops an expected beat on every handshake, checks held beats and back-to-back beats.
   initial begin
      beat_t cur, held, e;
      bit    stalled;
      bit    need_next;
      stalled   = 1'b0;
      need_next = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            stalled   = 1'b0;
            need_next = 1'b0;
         end else begin
            cur.bits = out_bits;
            cur.len  = out_len;
            cur.last = out_last;
            cur.esc  = is_escape;
            if (need_next) begin
               chk("no_bubble_between_beats", 32'(out_valid), 32'd1);
               need_next = 1'b0;
            end
            if (stalled) begin
               chk("stall_valid_held", 32'(out_valid), 32'd1);
               chk("stall_beat_held", 32'(cur), 32'(held));
            end
            stalled = 1'b0;
            if (out_valid && !out_ready) begin
               stalled = 1'b1;
               held    = cur;
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 32'(cur), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_bits", 32'(cur.bits), 32'(e.bits));
                  chk("beat_len",  32'(cur.len),  32'(e.len));
                  chk("beat_last", 32'(cur.last), 32'(e.last));
                  chk("beat_esc",  32'(cur.esc),  32'(e.esc));
                  need_next = !cur.last;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      MErrval   = '0;
      k         = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bits",  32'(out_bits),  32'd0);
      chk("rst_out_len",   32'(out_len),   32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_is_escape", 32'(is_escape), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      reset = 1'b0;

      // q=1, tail 101
      expb(16'h0005, 5'd4, 1'b1, 1'b0);
      send(9'd5, 4'd2);
      drain();

      // k=0, q=0: lone terminating one
      expb(16'h0001, 5'd1, 1'b1, 1'b0);
      send(9'd0, 4'd0);
      drain();

      // 20 zeros + '1'
      expb(16'h0000, 5'd16, 1'b0, 1'b0);
      expb(16'h0001, 5'd5,  1'b1, 1'b0);
      send(9'd20, 4'd0);
      drain();

      // escape, with out_ready held low on the first beat and in_valid poked while busy
      out_ready = 1'b0;
      expb(16'h0000, 5'd16, 1'b0, 1'b1);
      expb(16'h0127, 5'd16, 1'b1, 1'b1);
      send(9'd40, 4'd0);
      in_valid = 1'b1;
      MErrval  = 9'd5;
      k        = 4'd2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("in_ready_low_while_busy", 32'(in_ready), 32'd0);
         chk("busy_high_while_busy",    32'(busy),     32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // zeros + tail_len exactly CHUNK_W: one full beat
      expb(16'h0005, 5'd16, 1'b1, 1'b0);
      send(9'd53, 4'd2);
      drain();

      // zeros exactly one chunk: full zero beat then bare tail
      expb(16'h0000, 5'd16, 1'b0, 1'b0);
      expb(16'h0001, 5'd1,  1'b1, 1'b0);
      send(9'd16, 4'd0);
      drain();

      // k above MERR_W clamps to 9
      expb(16'h032C, 5'd10, 1'b1, 1'b0);
      send(9'd300, 4'd12);
      drain();

      // q=23: first escaping quotient
      expb(16'h0000, 5'd16, 1'b0, 1'b1);
      expb(16'h0116, 5'd16, 1'b1, 1'b1);
      send(9'd23, 4'd0);
      drain();

      // q=22: largest plain quotient
      expb(16'h0000, 5'd16, 1'b0, 1'b0);
      expb(16'h0001, 5'd7,  1'b1, 1'b0);
      send(9'd22, 4'd0);
      drain();

      // 12 zeros and a 6-bit tail do not fit one beat: short zero beat, then tail
      expb(16'h0000, 5'd12, 1'b0, 1'b0);
      expb(16'h0025, 5'd6,  1'b1, 1'b0);
      send(9'd389, 4'd5);
      drain();

      // largest MErrval escapes with (511-1)[7:0]
      expb(16'h0000, 5'd16, 1'b0, 1'b1);
      expb(16'h01FE, 5'd16, 1'b1, 1'b1);
      send(9'd511, 4'd0);
      drain();

      // reset in ZEROS discards the codeword
      out_ready = 1'b0;
      send(9'd20, 4'd0);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_out_valid", 32'(out_valid), 32'd0);
      chk("post_reset_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b1;
      expb(16'h0005, 5'd4, 1'b1, 1'b0);
      send(9'd5, 4'd2);
      drain();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
